// File: rtl/screen_write_arbiter_pkg.sv
// Screen geometry and port-owner encodings shared by the write arbiter and
// both screen loaders.
package screen_write_arbiter_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int X_MAX    = 159;
  localparam int Y_MAX    = 119;

  // The owner output is the FSM state itself, so these values double as
  // the state encoding.
  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_MAIN  = 2'd1,
    OWN_ANIM  = 2'd2,
    OWN_CLEAR = 2'd3
  } owner_e;

endpackage

// File: rtl/screen_write_arbiter_clear_counter.sv
// x-major raster counter for the clear engine: load zeroes it, enable steps
// one pixel, last flags (X_MAX, Y_MAX).
module screen_clear_counter #(
  parameter int X_W   = screen_write_arbiter_pkg::X_W,
  parameter int Y_W   = screen_write_arbiter_pkg::Y_W,
  parameter int X_MAX = screen_write_arbiter_pkg::X_MAX,
  parameter int Y_MAX = screen_write_arbiter_pkg::Y_MAX
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load_i,
  input  logic           en_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_wrap;

  assign x_wrap = (x_q == X_W'(X_MAX));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = x_wrap && (y_q == Y_W'(Y_MAX));

endmodule

// File: rtl/screen_write_arbiter.sv
// Arbitrates the single VGA pixel-write port between the main-screen loader,
// the animation loader and an internal full-frame clear engine.
module screen_write_arbiter #(
  parameter int X_W      = screen_write_arbiter_pkg::X_W,
  parameter int Y_W      = screen_write_arbiter_pkg::Y_W,
  parameter int COLOUR_W = screen_write_arbiter_pkg::COLOUR_W,
  parameter int X_MAX    = screen_write_arbiter_pkg::X_MAX,
  parameter int Y_MAX    = screen_write_arbiter_pkg::Y_MAX
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_done,
  input  logic                main_req,
  output logic                main_grant,
  input  logic                main_plot,
  input  logic [X_W-1:0]      main_x,
  input  logic [Y_W-1:0]      main_y,
  input  logic [COLOUR_W-1:0] main_colour,
  input  logic                main_done,
  input  logic                anim_req,
  output logic                anim_grant,
  input  logic                anim_plot,
  input  logic [X_W-1:0]      anim_x,
  input  logic [Y_W-1:0]      anim_y,
  input  logic [COLOUR_W-1:0] anim_colour,
  input  logic                anim_done,
  output logic                vga_plot,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic [1:0]          owner
);

  import screen_write_arbiter_pkg::*;

  owner_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic                last_anim_q, last_anim_d;   // 1: anim was served last
  logic [COLOUR_W-1:0] fill_q, fill_d;
  logic                plot_q, plot_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                done_q, done_d;
  logic                main_grant_q, anim_grant_q;

  logic                cnt_load, cnt_en, cnt_last;
  logic [X_W-1:0]      cnt_x;
  logic [Y_W-1:0]      cnt_y;

  screen_clear_counter #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_clear_cnt (
    .clock  (clock),
    .reset  (reset),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .x_o    (cnt_x),
    .y_o    (cnt_y),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | clear_req;
    last_anim_d = last_anim_q;
    fill_d      = fill_q;
    plot_d      = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    done_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      OWN_IDLE: begin
        if (pending_q) begin
          // A clear_req landing on the entry cycle re-arms for one more sweep.
          state_d   = OWN_CLEAR;
          pending_d = clear_req;
          fill_d    = clear_colour;
          cnt_load  = 1'b1;
        end else if (main_req && anim_req) begin
          state_d = last_anim_q ? OWN_MAIN : OWN_ANIM;
        end else if (main_req) begin
          state_d = OWN_MAIN;
        end else if (anim_req) begin
          state_d = OWN_ANIM;
        end
      end

      OWN_MAIN: begin
        if (main_plot) begin
          plot_d   = 1'b1;
          x_d      = main_x;
          y_d      = main_y;
          colour_d = main_colour;
        end
        if (main_done || !main_req) begin
          state_d     = OWN_IDLE;
          last_anim_d = 1'b0;
        end
      end

      OWN_ANIM: begin
        if (anim_plot) begin
          plot_d   = 1'b1;
          x_d      = anim_x;
          y_d      = anim_y;
          colour_d = anim_colour;
        end
        if (anim_done || !anim_req) begin
          state_d     = OWN_IDLE;
          last_anim_d = 1'b1;
        end
      end

      OWN_CLEAR: begin
        plot_d   = 1'b1;
        x_d      = cnt_x;
        y_d      = cnt_y;
        colour_d = fill_q;
        cnt_en   = 1'b1;
        if (cnt_last) begin
          state_d = OWN_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = OWN_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= OWN_IDLE;
      pending_q    <= 1'b0;
      last_anim_q  <= 1'b1;
      fill_q       <= '0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      done_q       <= 1'b0;
      main_grant_q <= 1'b0;
      anim_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_anim_q  <= last_anim_d;
      fill_q       <= fill_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      done_q       <= done_d;
      main_grant_q <= (state_d == OWN_MAIN);
      anim_grant_q <= (state_d == OWN_ANIM);
    end
  end

  assign owner      = state_q;
  assign main_grant = main_grant_q;
  assign anim_grant = anim_grant_q;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_screen_write_arbiter.sv
// Directed bench for screen_write_arbiter: loader handoff, round robin,
// non-owner masking, full-frame clears and reset abort.
module tb_screen_write_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic       clear_done;
  logic       main_req, main_grant, main_plot, main_done;
  logic [7:0] main_x;
  logic [6:0] main_y;
  logic [2:0] main_colour;
  logic       anim_req, anim_grant, anim_plot, anim_done;
  logic [7:0] anim_x;
  logic [6:0] anim_y;
  logic [2:0] anim_colour;
  logic       vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic [1:0] owner;

  int n_chk  = 0;
  int n_fail = 0;

  // sweep results
  int sw_plots, sw_err, sw_done_at, sw_gnt, sw_gap, sw_lx, sw_ly, sw_fx, sw_fy;

  screen_write_arbiter dut (
    .clock(clock), .reset(reset),
    .clear_req(clear_req), .clear_colour(clear_colour), .clear_done(clear_done),
    .main_req(main_req), .main_grant(main_grant), .main_plot(main_plot),
    .main_x(main_x), .main_y(main_y), .main_colour(main_colour), .main_done(main_done),
    .anim_req(anim_req), .anim_grant(anim_grant), .anim_plot(anim_plot),
    .anim_x(anim_x), .anim_y(anim_y), .anim_colour(anim_colour), .anim_done(anim_done),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .owner(owner)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Follows a clear from the CLEAR-entry cycle; stops on clear_done, after
  // stop_at plots, or when the cycle budget runs out.
  task automatic sweep(input logic [2:0] col, input int stop_at);
    int ex, ey;
    ex = 0; ey = 0;
    sw_plots = 0; sw_err = 0; sw_done_at = -1; sw_gnt = 0; sw_gap = 0;
    sw_lx = -1; sw_ly = -1; sw_fx = -1; sw_fy = -1;
    for (int i = 0; i < 19300; i++) begin
      tick();
      if (main_grant || anim_grant) sw_gnt++;
      if (vga_plot) begin
        if (sw_plots == 0) begin sw_fx = int'(vga_x); sw_fy = int'(vga_y); end
        if (int'(vga_x) != ex || int'(vga_y) != ey || vga_colour != col) sw_err++;
        sw_lx = int'(vga_x); sw_ly = int'(vga_y);
        sw_plots++;
        if (ex == 159) begin ex = 0; ey++; end else ex++;
      end else begin
        sw_gap++;
      end
      if (clear_done) begin
        sw_done_at = sw_plots;
        break;
      end
      if (sw_plots == stop_at) break;
    end
  endtask

  task automatic check_full_sweep(input string tag);
    check({tag, "_plots"},   sw_plots, 19200);
    check({tag, "_order"},   sw_err, 0);
    check({tag, "_gap"},     sw_gap, 0);
    check({tag, "_first_x"}, sw_fx, 0);
    check({tag, "_first_y"}, sw_fy, 0);
    check({tag, "_last_x"},  sw_lx, 159);
    check({tag, "_last_y"},  sw_ly, 119);
    check({tag, "_done_at"}, sw_done_at, 19200);
    check({tag, "_grants"},  sw_gnt, 0);
    check({tag, "_owner"},   owner, 0);
  endtask

  initial begin
    int stray;
    reset = 1'b1; clear_req = 0; clear_colour = 0;
    main_req = 0; main_plot = 0; main_done = 0; main_x = 0; main_y = 0; main_colour = 0;
    anim_req = 0; anim_plot = 0; anim_done = 0; anim_x = 0; anim_y = 0; anim_colour = 0;
    tick(); tick();
    check("rst_owner", owner, 0);
    check("rst_mgnt", main_grant, 0);
    check("rst_agnt", anim_grant, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    check("rst_done", clear_done, 0);
    reset = 1'b0;

    // main transfer
    main_req = 1;
    tick();
    check("m_grant", main_grant, 1);
    check("m_owner", owner, 1);
    main_plot = 1; main_x = 10; main_y = 20; main_colour = 3'b101;
    tick();
    check("m_plot", vga_plot, 1);
    check("m_x", vga_x, 10);
    check("m_y", vga_y, 20);
    check("m_col", vga_colour, 5);
    main_plot = 0; main_done = 1;
    tick();
    check("m_rel_grant", main_grant, 0);
    check("m_rel_owner", owner, 0);
    check("m_rel_plot", vga_plot, 0);
    check("m_hold_x", vga_x, 10);
    main_done = 0; main_req = 0;
    tick();

    // tie from reset: last_served=anim so main wins, then anim
    reset = 1; tick(); reset = 0;
    main_req = 1; anim_req = 1;
    tick();
    check("tie1_owner", owner, 1);
    check("tie1_agnt", anim_grant, 0);
    main_done = 1;
    tick();
    check("tie_idle", owner, 0);
    main_done = 0;
    tick();
    check("tie2_owner", owner, 2);
    check("tie2_agnt", anim_grant, 1);
    check("tie2_mgnt", main_grant, 0);
    // non-owner plot ignored
    main_plot = 1; main_x = 5; main_y = 5; main_colour = 7;
    tick();
    check("nonown_plot", vga_plot, 0);
    check("nonown_owner", owner, 2);
    main_plot = 0;
    anim_plot = 1; anim_x = 3; anim_y = 4; anim_colour = 6;
    tick();
    check("a_plot", vga_plot, 1);
    check("a_xyc", {vga_x, vga_y, vga_colour}, {8'd3, 7'd4, 3'd6});
    // plot coincident with done still forwarded
    anim_x = 1; anim_y = 2; anim_colour = 1; anim_done = 1;
    tick();
    check("a_done_plot", vga_plot, 1);
    check("a_done_x", vga_x, 1);
    check("a_done_owner", owner, 0);
    anim_plot = 0; anim_done = 0; anim_req = 0;
    tick();
    check("rr_main", owner, 1);
    main_req = 0;                       // req drop releases
    tick();
    check("drop_owner", owner, 0);
    check("drop_grant", main_grant, 0);

    // clear from IDLE; loader plots without grant must not disturb it
    clear_colour = 2; clear_req = 1;
    tick();
    clear_req = 0;
    anim_plot = 1; anim_x = 99; anim_y = 9; anim_colour = 7;
    tick();
    check("clr_enter", owner, 3);
    sweep(3'd2, -1);
    check_full_sweep("clr1");
    anim_plot = 0;
    tick();
    check("clr_after_plot", vga_plot, 0);

    // clear requested mid-MAIN waits for release and beats a waiting anim_req
    main_req = 1;
    tick();
    check("cm_owner", owner, 1);
    clear_req = 1; anim_req = 1; clear_colour = 4;
    main_plot = 1; main_x = 7; main_y = 8; main_colour = 1;
    tick();
    clear_req = 0; clear_colour = 6;
    check("cm_still_main", owner, 1);
    check("cm_fwd", vga_plot, 1);
    main_plot = 0; main_done = 1; main_req = 0;
    tick();
    check("cm_idle", owner, 0);
    main_done = 0;
    tick();
    check("cm_clear", owner, 3);
    check("cm_agnt", anim_grant, 0);
    sweep(3'd6, -1);
    check_full_sweep("clr2");
    tick();
    check("cm_anim_after", owner, 2);
    check("cm_anim_grant", anim_grant, 1);
    anim_done = 1; anim_req = 0;
    tick();
    anim_done = 0;

    // reset during a clear aborts it; a new clear restarts from (0,0)
    clear_colour = 3; clear_req = 1;
    tick();
    clear_req = 0;
    tick();
    check("ab_enter", owner, 3);
    sweep(3'd3, 5000);
    check("ab_plots", sw_plots, 5000);
    check("ab_order", sw_err, 0);
    reset = 1;
    tick();
    check("ab_rst_all", {vga_plot, vga_x, vga_y, vga_colour, owner, main_grant, anim_grant}, 0);
    check("ab_rst_done", clear_done, 0);
    reset = 0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vga_plot || clear_done) stray++;
    end
    check("ab_no_resume", stray, 0);
    clear_colour = 5; clear_req = 1;
    tick();
    clear_req = 0;
    tick();
    sweep(3'd5, -1);
    check_full_sweep("clr3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
